// File: rtl/psi_ro_pkg.sv
//------------------------------------------------------------------------------
// psi_ro_pkg
// Shared constants, oscillator state encoding and the half-period clamp
// for the PSI-controlled ring oscillator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package psi_ro_pkg;

  localparam int WIN_LOG2  = 8;    // duty window = 2**WIN_LOG2 clk cycles
  localparam int BASE_HALF = 260;  // half-period at psi_level = 0
  localparam int MIN_HALF  = 4;    // fastest allowed half-period
  localparam int HALF_W    = 16;   // half-period counter width

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } osc_state_e;

  // Half-period shrinks by one clk per level step, clamped at min_half.
  // Signed int arithmetic keeps a level above base from wrapping.
  function automatic int calc_half(input int base, input int min_half, input int level);
    int diff;
    diff = base - level;
    return (diff < min_half) ? min_half : diff;
  endfunction

endpackage

`default_nettype wire

// File: rtl/psi_duty_meter.sv
//------------------------------------------------------------------------------
// psi_duty_meter
// Counts PSI high cycles over a fixed window and publishes the saturated
// count as an 8-bit level with a one-cycle valid pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module psi_duty_meter #(
  parameter int WIN_LOG2 = psi_ro_pkg::WIN_LOG2
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       PSI,
  output logic [7:0] psi_level,
  output logic       level_valid
);

  import psi_ro_pkg::*;

  localparam int SUM_W = WIN_LOG2 + 1;

  logic [WIN_LOG2-1:0] cyc_cnt_q;
  logic [SUM_W-1:0]    hi_cnt_q;
  logic [SUM_W-1:0]    sum_d;
  logic [7:0]          level_q;
  logic                valid_q;

  // The final window sample is folded in combinationally so it is counted.
  assign sum_d = hi_cnt_q + SUM_W'(PSI);

  // Window accumulation, saturated publish and counter restart.
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      cyc_cnt_q <= '0;
      hi_cnt_q  <= '0;
      level_q   <= 8'd0;
      valid_q   <= 1'b0;
    end else if (&cyc_cnt_q) begin
      level_q   <= (32'(sum_d) > 32'd255) ? 8'hFF : 8'(sum_d);
      valid_q   <= 1'b1;
      cyc_cnt_q <= '0;
      hi_cnt_q  <= '0;
    end else begin
      valid_q   <= 1'b0;
      cyc_cnt_q <= cyc_cnt_q + WIN_LOG2'(1);
      hi_cnt_q  <= sum_d;
    end
  end

  assign psi_level   = level_q;
  assign level_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/psi_controlled_ro.sv
//------------------------------------------------------------------------------
// psi_controlled_ro
// Supply-controlled ring oscillator model: PSI duty sets the level, the
// level sets the half-period of a glitch-free square wave on ro_out.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module psi_controlled_ro #(
  parameter int WIN_LOG2  = psi_ro_pkg::WIN_LOG2,
  parameter int BASE_HALF = psi_ro_pkg::BASE_HALF,
  parameter int MIN_HALF  = psi_ro_pkg::MIN_HALF,
  parameter int HALF_W    = psi_ro_pkg::HALF_W
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              ring_on,
  input  logic              PSI,
  output logic              ro_out,
  output logic [7:0]        psi_level,
  output logic              level_valid,
  output logic [HALF_W-1:0] half_period
);

  import psi_ro_pkg::*;

  localparam logic [HALF_W-1:0] ONE = HALF_W'(1);

  osc_state_e        state_q;
  logic [HALF_W-1:0] cnt_q;
  logic [HALF_W-1:0] half_q;
  logic [HALF_W-1:0] half_eff_d;
  logic              ro_q;
  logic [7:0]        level_w;
  logic              valid_w;

  psi_duty_meter #(
    .WIN_LOG2    (WIN_LOG2)
  ) u_meter (
    .clk_50MHz   (clk_50MHz),
    .rst         (rst),
    .PSI         (PSI),
    .psi_level   (level_w),
    .level_valid (valid_w)
  );

  // Uses the registered level, so a same-edge level update waits one reload.
  assign half_eff_d = HALF_W'(calc_half(BASE_HALF, MIN_HALF, {24'd0, level_w}));

  // Oscillator FSM: new half-periods are taken only at a reload.
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= HALF_W'(BASE_HALF);
      ro_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ro_q <= 1'b0;
          if (ring_on) begin
            state_q <= RUN;
            cnt_q   <= half_eff_d - ONE;
            half_q  <= half_eff_d;
          end
        end
        RUN: begin
          if (!ring_on) begin
            state_q <= IDLE;
            ro_q    <= 1'b0;
          end else if (cnt_q == '0) begin
            ro_q    <= ~ro_q;
            cnt_q   <= half_eff_d - ONE;
            half_q  <= half_eff_d;
          end else begin
            cnt_q   <= cnt_q - ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          ro_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ro_out      = ro_q;
  assign psi_level   = level_w;
  assign level_valid = valid_w;
  assign half_period = half_q;

endmodule

`default_nettype wire

// File: tb/tb_psi_controlled_ro.sv
//------------------------------------------------------------------------------
// tb_psi_controlled_ro
// Self-checking bench with a timestamp-based reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_psi_controlled_ro;

  logic        clk_50MHz = 1'b0;
  logic        rst       = 1'b0;
  logic        ring_on   = 1'b0;
  logic        PSI       = 1'b0;
  logic        ro_out;
  logic [7:0]  psi_level;
  logic        level_valid;
  logic [15:0] half_period;

  int checks   = 0;
  int failures = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  psi_controlled_ro dut (
    .clk_50MHz   (clk_50MHz),
    .rst         (rst),
    .ring_on     (ring_on),
    .PSI         (PSI),
    .ro_out      (ro_out),
    .psi_level   (psi_level),
    .level_valid (level_valid),
    .half_period (half_period)
  );

  wire [25:0] act_vec = {ro_out, level_valid, psi_level, half_period};

  // Reference model: window tally plus absolute time of the next toggle.
  int     m_cyc, m_ones, m_level, m_half;
  bit     m_valid, m_ro, m_run;
  longint now, m_next;

  function automatic int half_of(input int lvl);
    return (260 - lvl >= 4) ? 260 - lvl : 4;
  endfunction

  function automatic logic [25:0] exp_vec();
    logic [7:0]  l;
    logic [15:0] h;
    l = m_level[7:0];
    h = m_half[15:0];
    return {m_ro, m_valid, l, h};
  endfunction

  task automatic model_edge(input bit r, input bit on, input bit p);
    int lvl_before, h;
    now++;
    if (!r) begin
      m_cyc = 0; m_ones = 0; m_level = 0; m_valid = 0;
      m_ro = 0; m_run = 0; m_half = 260;
    end else begin
      lvl_before = m_level;
      m_valid = 0;
      m_ones += int'(p);
      m_cyc++;
      if (m_cyc == 256) begin
        m_level = (m_ones > 255) ? 255 : m_ones;
        m_valid = 1;
        m_cyc = 0;
        m_ones = 0;
      end
      h = half_of(lvl_before);
      if (!m_run) begin
        m_ro = 0;
        if (on) begin m_run = 1; m_next = now + h; m_half = h; end
      end else if (!on) begin
        m_run = 0; m_ro = 0;
      end else if (now == m_next) begin
        m_ro = !m_ro; m_next = now + h; m_half = h;
      end
    end
  endtask

  task automatic tick(input bit r, input bit on, input bit p);
    @(negedge clk_50MHz);
    rst = r; ring_on = on; PSI = p;
    @(posedge clk_50MHz);
    model_edge(r, on, p);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      checks++;
      if (act_vec !== {1'b0, 1'b0, 8'd0, 16'd260}) begin
        failures++;
        $display("FAIL reset i=%0d got=%h want=%h", i, act_vec, {1'b0, 1'b0, 8'd0, 16'd260});
      end
    end
  endtask

  task automatic test_psi_zero();
    int r1, r2;
    logic prev;
    r1 = -1; r2 = -1;
    do_reset(2);
    for (int k = 1; k <= 1100; k++) begin
      prev = ro_out;
      tick(1'b1, 1'b1, 1'b0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL psi_zero_model k=%0d got=%h want=%h", k, act_vec, exp_vec());
      end
      if (level_valid) begin
        checks++;
        if ((k % 256) != 0 || psi_level !== 8'd0) begin
          failures++;
          $display("FAIL psi_zero_valid k=%0d level=%0d want_k_mult_256 level=0", k, psi_level);
        end
      end
      if (ro_out && !prev) begin
        if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
      end
    end
    checks++;
    if (r1 != 261) begin failures++; $display("FAIL psi_zero_first_rise got=%0d want=261", r1); end
    checks++;
    if (r2 - r1 != 520) begin failures++; $display("FAIL psi_zero_period got=%0d want=520", r2 - r1); end
  endtask

  task automatic test_duty(input string name, input int mod, input int want_lvl,
                           input int want_half, input int ncyc);
    int rp, rl;
    logic prev;
    rp = -1; rl = -1;
    do_reset(2);
    for (int k = 1; k <= ncyc; k++) begin
      prev = ro_out;
      tick(1'b1, 1'b1, (k % mod) == 0);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL %s_model k=%0d got=%h want=%h", name, k, act_vec, exp_vec());
      end
      if (ro_out && !prev) begin rp = rl; rl = k; end
    end
    checks++;
    if (psi_level !== 8'(want_lvl)) begin
      failures++; $display("FAIL %s_level got=%0d want=%0d", name, psi_level, want_lvl);
    end
    checks++;
    if (half_period !== 16'(want_half)) begin
      failures++; $display("FAIL %s_half got=%0d want=%0d", name, half_period, want_half);
    end
    checks++;
    if (rl - rp != 2 * want_half) begin
      failures++; $display("FAIL %s_period got=%0d want=%0d", name, rl - rp, 2 * want_half);
    end
  endtask

  task automatic test_mid_change();
    do_reset(2);
    for (int k = 1; k <= 800; k++) begin
      tick(1'b1, k >= 252, k > 256);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL mid_change_model k=%0d got=%h want=%h", k, act_vec, exp_vec());
      end
      if (k == 512) begin
        checks++;
        if (!(ro_out === 1'b1 && half_period === 16'd260 && level_valid === 1'b1 && psi_level === 8'd255)) begin
          failures++;
          $display("FAIL mid_change_coincide ro=%b half=%0d vld=%b lvl=%0d want ro=1 half=260 vld=1 lvl=255",
                   ro_out, half_period, level_valid, psi_level);
        end
      end
      if (k == 772) begin
        checks++;
        if (!(ro_out === 1'b0 && half_period === 16'd5)) begin
          failures++;
          $display("FAIL mid_change_full_phase ro=%b half=%0d want ro=0 half=5", ro_out, half_period);
        end
      end
      if (k == 777) begin
        checks++;
        if (ro_out !== 1'b1) begin
          failures++; $display("FAIL mid_change_fast_phase ro=%b want=1", ro_out);
        end
      end
    end
  endtask

  task automatic test_ring_off();
    do_reset(2);
    for (int k = 1; k <= 600; k++) begin
      tick(1'b1, (k < 300) || (k >= 310), (k % 2) == 1);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL ring_off_model k=%0d got=%h want=%h", k, act_vec, exp_vec());
      end
      if (k == 299 || k == 300 || k == 441 || k == 442) begin
        checks++;
        if (ro_out !== ((k == 299) || (k == 442))) begin
          failures++;
          $display("FAIL ring_off_edge k=%0d got=%b want=%b", k, ro_out, (k == 299) || (k == 442));
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    int first;
    first = -1;
    do_reset(2);
    for (int k = 1; k <= 100; k++) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b1);
    for (int j = 1; j <= 300; j++) begin
      tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL rst_mid_model j=%0d got=%h want=%h", j, act_vec, exp_vec());
      end
      if (level_valid && first < 0) first = j;
    end
    checks++;
    if (first != 256) begin failures++; $display("FAIL rst_mid_first_valid got=%0d want=256", first); end
  endtask

  task automatic test_random();
    int  duty;
    bit  on, r, p;
    duty = 50; on = 1;
    do_reset(2);
    for (int k = 1; k <= 3000; k++) begin
      if (k % 300 == 0) duty = $urandom_range(0, 100);
      if ($urandom_range(0, 399) == 0) on = !on;
      r = ($urandom_range(0, 1499) != 0);
      p = ($urandom_range(0, 99) < duty);
      tick(r, on, p);
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_model k=%0d got=%h want=%h", k, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    now = 0; m_next = 0;
    m_cyc = 0; m_ones = 0; m_level = 0; m_half = 260;
    m_valid = 0; m_ro = 0; m_run = 0;
    test_reset();
    test_psi_zero();
    test_duty("full_duty", 1, 255, 5, 700);
    test_duty("quarter_duty", 4, 64, 196, 1400);
    test_mid_change();
    test_ring_off();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
